frame_update_sched: RTL and testbench

FRAME_UPDATE_SCHED -- requirements
Module: frame_update_sched

---
 rtl/frame_update_sched.sv | 181 ++++++++++++++++++
 tb/tb_frame_update_sched.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_update_sched.sv
// rtl/frame_update_sched.sv - once-per-N-frames round-robin update scheduler with 4-phase req/ack handshakes.
// Optional build macro FRAME_UPDATE_SCHED_TIMEOUT_EN enables the per-requester REQ timeout.
module frame_update_sched #(
  parameter int TIMEOUT   = 255,
  parameter int FRAME_DIV = 1
) (
  input  logic        vgaclk,
  input  logic        clr,
  input  logic        vsync,
  input  logic        en,
  input  logic [3:0]  req_mask,
  input  logic [3:0]  ack,
  input  logic        err_clr,
  output logic [3:0]  req,
  output logic        busy,
  output logic        done,
  output logic [15:0] frame_cnt,
  output logic        overrun,
  output logic [3:0]  timeout_err
);

  typedef enum logic [2:0] {S_IDLE, S_SEL, S_REQ, S_REL, S_DONE} state_t;

  localparam logic [3:0] DIV_LAST = 4'(FRAME_DIV - 1);

  state_t      state_q;
  logic [1:0]  idx_q;
  logic [3:0]  req_q;
  logic        busy_q;
  logic        done_q;
  logic        vs_q;
  logic [3:0]  div_q, div_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        overrun_q, overrun_d;
  logic        frame_start;
  logic        round_start;
  logic [3:0]  idx_onehot;

  assign frame_start = ~vsync & vs_q;
  assign round_start = frame_start & en & (state_q == S_IDLE) & (div_q == 4'd0);
  assign idx_onehot  = 4'b0001 << idx_q;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    div_d       = div_q;
    if (frame_start) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
      div_d       = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
    end
    // A set in the same cycle as err_clr takes precedence.
    overrun_d = (err_clr ? 1'b0 : overrun_q) | (frame_start & (state_q != S_IDLE));
  end

  always_ff @(posedge vgaclk or posedge clr) begin
    if (clr) begin
      vs_q        <= 1'b1;
      div_q       <= 4'd0;
      frame_cnt_q <= 16'd0;
      overrun_q   <= 1'b0;
    end else begin
      vs_q        <= vsync;
      div_q       <= div_d;
      frame_cnt_q <= frame_cnt_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef FRAME_UPDATE_SCHED_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] tcnt_q;
  logic       to_hit;
  logic [3:0] timeout_err_q, timeout_err_d;

  assign to_hit = (state_q == S_REQ) & ~ack[idx_q] & (tcnt_q == TO_LAST);

  always_comb begin
    timeout_err_d = (err_clr ? 4'b0000 : timeout_err_q) | (to_hit ? idx_onehot : 4'b0000);
  end

  always_ff @(posedge vgaclk or posedge clr) begin
    if (clr) begin
      tcnt_q        <= 8'd0;
      timeout_err_q <= 4'b0000;
    end else begin
      timeout_err_q <= timeout_err_d;
      if (state_q != S_REQ) begin
        tcnt_q <= 8'd0;
      end else if (!ack[idx_q] && !to_hit) begin
        tcnt_q <= tcnt_q + 8'd1;
      end
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic unused_timeout;

  assign unused_timeout = |8'(TIMEOUT);
  assign timeout_err    = 4'b0000;
`endif

  always_ff @(posedge vgaclk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      req_q   <= 4'b0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (round_start) begin
            state_q <= S_SEL;
            idx_q   <= 2'd0;
            busy_q  <= 1'b1;
          end
        end
        S_SEL: begin
          if (req_mask[idx_q]) begin
            state_q <= S_REQ;
            req_q   <= idx_onehot;
          end else if (idx_q == 2'd3) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            idx_q <= idx_q + 2'd1;
          end
        end
        S_REQ: begin
          if (ack[idx_q]) begin
            req_q   <= 4'b0000;
            state_q <= S_REL;
          end
`ifdef FRAME_UPDATE_SCHED_TIMEOUT_EN
          // Abandon a silent requester and move on without waiting for release.
          else if (to_hit) begin
            req_q <= 4'b0000;
            if (idx_q == 2'd3) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              idx_q   <= idx_q + 2'd1;
              state_q <= S_SEL;
            end
          end
`endif
        end
        S_REL: begin
          if (!ack[idx_q]) begin
            if (idx_q == 2'd3) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              idx_q   <= idx_q + 2'd1;
              state_q <= S_SEL;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          idx_q   <= 2'd0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 4'b0000;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req       = req_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_cnt = frame_cnt_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_frame_update_sched.sv
// tb/tb_frame_update_sched.sv - directed scoreboard bench for frame_update_sched.
module tb_frame_update_sched;
  localparam int TO = 10;
  localparam int FD = 3;

  logic        vgaclk = 1'b0;
  logic        clr = 1'b1;
  logic        vsync = 1'b1;
  logic        en = 1'b0;
  logic        err_clr = 1'b0;
  logic [3:0]  req_mask = 4'b0000;
  logic [3:0]  ack = 4'b0000;
  logic [3:0]  req;
  logic [3:0]  timeout_err;
  logic        busy;
  logic        done;
  logic        overrun;
  logic [15:0] frame_cnt;

  int total = 0;
  int bad = 0;
  int done_seen = 0;
  logic [3:0] exp_q[$];
  logic [3:0] stall = 4'b0000;
  logic [3:0] prev_req = 4'b0000;
  int ack_cnt[4] = '{0, 0, 0, 0};

  frame_update_sched #(.TIMEOUT(TO), .FRAME_DIV(FD)) dut (
    .vgaclk(vgaclk), .clr(clr), .vsync(vsync), .en(en), .req_mask(req_mask),
    .ack(ack), .err_clr(err_clr), .req(req), .busy(busy), .done(done),
    .frame_cnt(frame_cnt), .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 vgaclk = ~vgaclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Requester model: ack two cycles after req, release once req falls.
  always @(negedge vgaclk) begin
    for (int i = 0; i < 4; i++) begin
      if (clr || stall[i] || !req[i]) begin
        ack[i] = 1'b0;
        ack_cnt[i] = 0;
      end else if (ack_cnt[i] == 1) begin
        ack[i] = 1'b1;
      end else begin
        ack_cnt[i]++;
      end
    end
  end

  // Scoreboard: every new request must match the next expected one-hot value.
  always @(negedge vgaclk) begin
    if (req !== prev_req && req !== 4'b0000) begin
      if (exp_q.size() == 0) check("req_unexpected", 32'(req), 32'd0);
      else check("req_order", 32'(req), 32'(exp_q.pop_front()));
    end
    if (!$onehot0(req)) check("req_onehot", 32'(req), 32'd0);
    if (done === 1'b1) done_seen++;
    prev_req = req;
  end

  task automatic tick();
    @(negedge vgaclk);
  endtask

  task automatic do_reset();
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
  endtask

  task automatic run_round(input string tag, input logic [3:0] mask, input int exp_busy);
    int nb;
    int d0;
    nb = 0;
    d0 = done_seen;
    req_mask = mask;
    for (int i = 0; i < 4; i++) if (mask[i]) exp_q.push_back(4'(1 << i));
    vsync = 1'b0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (c == 1) vsync = 1'b1;
      if (busy) nb++;
    end
    check({tag, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
    check({tag, "_done_pulses"}, 32'(done_seen - d0), 32'd1);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int d0;
    int hi;
    int c;

    tick();
    tick();
    check("rst_req", 32'(req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    clr = 1'b0;
    tick();

    en = 1'b1;
    run_round("mask_f", 4'hF, 17);
    check("mask_f_frame_cnt", 32'(frame_cnt), 32'd1);

    do_reset();
    run_round("mask_5", 4'h5, 11);

    do_reset();
    run_round("mask_0", 4'h0, 5);

    do_reset();
    en = 1'b0;
    d0 = done_seen;
    vsync = 1'b0;
    hi = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 1) vsync = 1'b1;
      if (busy) hi++;
    end
    check("en0_busy_cycles", 32'(hi), 32'd0);
    check("en0_done", 32'(done_seen - d0), 32'd0);
    check("en0_frame_cnt", 32'(frame_cnt), 32'd1);

    do_reset();
    en = 1'b1;
    req_mask = 4'h1;
    for (int f = 1; f <= 6; f++) begin
      if (f == 1 || f == 4) exp_q.push_back(4'h1);
      d0 = done_seen;
      vsync = 1'b0;
      tick();
      tick();
      vsync = 1'b1;
      repeat (25) tick();
      check($sformatf("div_frame%0d_done", f), 32'(done_seen - d0), (f == 1 || f == 4) ? 32'd1 : 32'd0);
    end
    check("div_frame_cnt", 32'(frame_cnt), 32'd6);
    check("div_queue_left", 32'(exp_q.size()), 32'd0);

    do_reset();
    req_mask = 4'hF;
    stall = 4'b0010;
    exp_q.push_back(4'h1);
    exp_q.push_back(4'h2);
`ifdef FRAME_UPDATE_SCHED_TIMEOUT_EN
    exp_q.push_back(4'h4);
    exp_q.push_back(4'h8);
`endif
    d0 = done_seen;
    vsync = 1'b0;
    c = 0;
    while (req !== 4'h2 && c < 40) begin
      tick();
      if (c == 1) vsync = 1'b1;
      c++;
    end
    check("stall_req1_seen", 32'(req), 32'h2);
    hi = 1;
    vsync = 1'b0;
    tick(); if (req === 4'h2) hi++;
    tick(); if (req === 4'h2) hi++;
    vsync = 1'b1;
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_req_kept", 32'(req), 32'h2);
    check("ovr_busy", 32'(busy), 32'd1);
    check("ovr_frame_cnt", 32'(frame_cnt), 32'd2);
    err_clr = 1'b1;
    tick(); if (req === 4'h2) hi++;
    err_clr = 1'b0;
    tick(); if (req === 4'h2) hi++;
    check("ovr_cleared", 32'(overrun), 32'd0);
`ifdef FRAME_UPDATE_SCHED_TIMEOUT_EN
    c = 0;
    while (req === 4'h2 && c < 40) begin
      tick();
      if (req === 4'h2) hi++;
      c++;
    end
    check("to_req1_cycles", 32'(hi), 32'(TO));
    check("to_err", 32'(timeout_err), 32'h2);
    c = 0;
    while (busy !== 1'b0 && c < 60) begin
      tick();
      c++;
    end
    check("to_round_end", 32'(busy), 32'd0);
    check("to_done", 32'(done_seen - d0), 32'd1);
    check("to_queue_left", 32'(exp_q.size()), 32'd0);
`else
    repeat (30) tick();
    check("nto_busy_stuck", 32'(busy), 32'd1);
    check("nto_req_held", 32'(req), 32'h2);
    check("nto_err_zero", 32'(timeout_err), 32'd0);
    check("nto_no_done", 32'(done_seen - d0), 32'd0);
`endif

    stall = 4'b0000;
    do_reset();
    req_mask = 4'h4;
    stall = 4'b0100;
    exp_q.push_back(4'h4);
    d0 = done_seen;
    vsync = 1'b0;
    c = 0;
    while (req !== 4'h4 && c < 40) begin
      tick();
      if (c == 1) vsync = 1'b1;
      c++;
    end
    check("clr_req2_seen", 32'(req), 32'h4);
    #1 clr = 1'b1;
    #1;
    check("clr_req_async", 32'(req), 32'd0);
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_done", 32'(done), 32'd0);
    check("clr_frame_cnt", 32'(frame_cnt), 32'd0);
    check("clr_overrun", 32'(overrun), 32'd0);
    check("clr_timeout_err", 32'(timeout_err), 32'd0);
    tick();
    clr = 1'b0;
    stall = 4'b0000;
    repeat (10) tick();
    check("clr_no_resume_busy", 32'(busy), 32'd0);
    check("clr_no_resume_req", 32'(req), 32'd0);
    check("clr_no_done", 32'(done_seen - d0), 32'd0);
    check("final_queue_left", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
